pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Pipeline controller: produces the enable/flush pair for every pipeline register (if/id, id/ex, ex/mem, mem/wb) plus pc_en.
//  It resolves load-use hazards, taken-branch squashes, multi-cycle data-memory access and halt/resume.
//  Consumes the control fields that ex/mem and id/ex publish, and drives en_exmem/flush_exmem et al.
// PARAMETERS
//  MEM_LAT  2  cycles a load/store occupies the MEM stage (>=1; 1 = no memory stall)
// PORTS
//  clk             in   1  clock
//  reset           in   1  synchronous, active-high reset
//  ra_id, rb_id    in   3  source register addresses of instruction in ID
//  use_ra_id       in   1  ID instruction reads ra
//  use_rb_id       in   1  ID instruction reads rb
//  from_main_mem_ex in  1  EX instruction is a load
//  regwrite_ex     in   1  EX instruction writes a register
//  regwrite_adr_ex in   3  EX destination register
//  branch_taken_ex in   1  EX instruction redirects PC
//  main_mem_write  in   1  MEM instruction is a store
//  from_main_mem_mem in 1  MEM instruction is a load
//  is_halt         in   1  MEM instruction is HLT
//  resume          in   1  external restart pulse
//  pc_en           out  1  PC update enable
//  en_ifid, en_idex, en_exmem, en_memwb            out 1 each  register enables
//  flush_ifid, flush_idex, flush_exmem, flush_memwb out 1 each  insert bubble on next edge
//  dmem_we         out  1  data-memory write strobe (exactly one cycle per store)
//  halted          out  1  core is halted
// BEHAVIOUR
//  State RUN/WAIT/HALTED (2-bit) + stall counter cnt [$clog2(MEM_LAT+1)-1:0].
//  Reset: state<=RUN, cnt<=0. While reset is high, dmem_we=0, halted=0, all en=1, all flush=0.
//  Outputs are combinational from state, cnt and inputs. Default (no event): all en=1, all flush=0.
//  memacc = main_mem_write|from_main_mem_mem; release = (MEM_LAT==1) | (state==WAIT & cnt==MEM_LAT-1).
//  Priority within RUN/WAIT (highest first): halt > memory stall > load-use > branch.
//  Halt: RUN & is_halt -> HALTED next edge. In the is_halt cycle and in HALTED: pc_en and en_ifid/idex/exmem = 0,
//    en_memwb=1 with flush_memwb=1, halted=1 (HALTED only). HALTED & resume -> RUN; that cycle: flush_exmem=1,
//    other enables 1 (HLT retires, younger instructions advance). resume outside HALTED is ignored.
//  Memory stall: memacc & !release -> pc_en, en_ifid/idex/exmem=0; en_memwb=1, flush_memwb=1 (no repeated
//    writeback). RUN -> WAIT with cnt<=1; WAIT & !release -> cnt<=cnt+1. On release: pipeline advances,
//    state<=RUN, cnt<=0. Access therefore holds MEM for exactly MEM_LAT cycles; dmem_we = main_mem_write & release.
//  Load-use (lu): from_main_mem_ex & regwrite_ex & ((use_ra_id & ra_id==regwrite_adr_ex)|(use_rb_id &
//    rb_id==regwrite_adr_ex)) -> pc_en=0, en_ifid=0, flush_idex=1, one bubble; detection re-evaluated next cycle.
//  Branch: branch_taken_ex -> flush_ifid=1, flush_idex=1, pc_en=1 (loads target).
//  Branch + lu in same cycle: branch wins (ID instruction is squashed anyway), no lu stall.
//  Branch/lu during memory stall: suppressed (EX frozen), evaluated again when stall releases.
//  Reset mid-WAIT or mid-HALTED: returns to RUN, cnt=0, no dmem_we pulse emitted in that cycle.
// STRUCTURE
//  pipe_pkg: typedef enum logic [1:0] {RUN, WAIT, HALTED} pipe_state_t; localparam DEFAULT_MEM_LAT = 2.
//  Sub-module loaduse_detect (combinational compare producing lu); state/counter in pipe_ctrl.
// TESTING
//  MEM_LAT=3, store in MEM at t0 -> en_exmem=0 at t0,t1; dmem_we=1 only at t2; state RUN at t3.
//  MEM_LAT=1, back-to-back loads -> no stall ever, pc_en=1 every cycle.
//  Load r3 in EX, ID uses rb=3 -> one cycle pc_en=0, en_ifid=0, flush_idex=1; next cycle all en=1.
//  branch_taken_ex with matching lu same cycle -> flush_ifid=flush_idex=1, pc_en=1, no stall.
//  is_halt at t0 -> halted=1 from t1, enables 0; resume at t5 -> flush_exmem=1 at t5, halted=0 at t6.
//  reset asserted at WAIT cnt=1 (MEM_LAT=3, store) -> next cycle RUN, cnt=0; dmem_we never pulses.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline controller: FSM state encoding and the
// bundle of enable/flush controls it drives each cycle.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        WAIT   = 2'd1,
        HALTED = 2'd2
    } pipe_state_t;

    localparam int DEFAULT_MEM_LAT = 2;

    typedef struct packed {
        logic pc_en;
        logic en_ifid;
        logic en_idex;
        logic en_exmem;
        logic en_memwb;
        logic flush_ifid;
        logic flush_idex;
        logic flush_exmem;
        logic flush_memwb;
        logic dmem_we;
        logic halted;
    } pipe_ctl_t;

    localparam pipe_ctl_t CTL_DEFAULT = '{
        pc_en: 1'b1, en_ifid: 1'b1, en_idex: 1'b1, en_exmem: 1'b1, en_memwb: 1'b1,
        flush_ifid: 1'b0, flush_idex: 1'b0, flush_exmem: 1'b0, flush_memwb: 1'b0,
        dmem_we: 1'b0, halted: 1'b0
    };

    // Front of the pipe frozen; MEM/WB keeps clocking but takes a bubble so
    // the instruction held in MEM never writes back twice.
    localparam pipe_ctl_t CTL_FREEZE = '{
        pc_en: 1'b0, en_ifid: 1'b0, en_idex: 1'b0, en_exmem: 1'b0, en_memwb: 1'b1,
        flush_ifid: 1'b0, flush_idex: 1'b0, flush_exmem: 1'b0, flush_memwb: 1'b1,
        dmem_we: 1'b0, halted: 1'b0
    };

endpackage

// File: rtl/pipe_ctrl_if.sv
// Control-field and enable/flush bundle between the pipeline datapath
// (master) and the pipeline controller (slave).
interface pipe_ctrl_if;

    logic [2:0] ra_id;
    logic [2:0] rb_id;
    logic       use_ra_id;
    logic       use_rb_id;
    logic       from_main_mem_ex;
    logic       regwrite_ex;
    logic [2:0] regwrite_adr_ex;
    logic       branch_taken_ex;
    logic       main_mem_write;
    logic       from_main_mem_mem;
    logic       is_halt;
    logic       resume;

    logic       pc_en;
    logic       en_ifid, en_idex, en_exmem, en_memwb;
    logic       flush_ifid, flush_idex, flush_exmem, flush_memwb;
    logic       dmem_we;
    logic       halted;

    modport master (
        output ra_id, rb_id, use_ra_id, use_rb_id, from_main_mem_ex, regwrite_ex,
               regwrite_adr_ex, branch_taken_ex, main_mem_write, from_main_mem_mem,
               is_halt, resume,
        input  pc_en, en_ifid, en_idex, en_exmem, en_memwb,
               flush_ifid, flush_idex, flush_exmem, flush_memwb, dmem_we, halted
    );

    modport slave (
        input  ra_id, rb_id, use_ra_id, use_rb_id, from_main_mem_ex, regwrite_ex,
               regwrite_adr_ex, branch_taken_ex, main_mem_write, from_main_mem_mem,
               is_halt, resume,
        output pc_en, en_ifid, en_idex, en_exmem, en_memwb,
               flush_ifid, flush_idex, flush_exmem, flush_memwb, dmem_we, halted
    );

endinterface

// File: rtl/pipe_ctrl_loaduse_detect.sv
// Load-use hazard: the load in EX produces a register that the ID
// instruction actually reads.
module loaduse_detect (
    input  logic [2:0] ra_id,
    input  logic [2:0] rb_id,
    input  logic       use_ra_id,
    input  logic       use_rb_id,
    input  logic       from_main_mem_ex,
    input  logic       regwrite_ex,
    input  logic [2:0] regwrite_adr_ex,
    output logic       lu
);

    logic hit_ra, hit_rb;

    assign hit_ra = use_ra_id && (ra_id == regwrite_adr_ex);
    assign hit_rb = use_rb_id && (rb_id == regwrite_adr_ex);
    assign lu     = from_main_mem_ex && regwrite_ex && (hit_ra || hit_rb);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: per-register enable/flush, PC enable and store strobe,
// sequencing halt/resume, multi-cycle memory stalls, load-use and branches.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_LAT = DEFAULT_MEM_LAT
) (
    input  logic        clk,
    input  logic        reset,
    pipe_ctrl_if.slave  bus
);

    localparam int CW = $clog2(MEM_LAT + 1);

    pipe_state_t   state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          lu, memacc, mem_release;
    pipe_ctl_t     ctl;

    loaduse_detect u_lu (
        .ra_id            (bus.ra_id),
        .rb_id            (bus.rb_id),
        .use_ra_id        (bus.use_ra_id),
        .use_rb_id        (bus.use_rb_id),
        .from_main_mem_ex (bus.from_main_mem_ex),
        .regwrite_ex      (bus.regwrite_ex),
        .regwrite_adr_ex  (bus.regwrite_adr_ex),
        .lu               (lu)
    );

    assign memacc      = bus.main_mem_write || bus.from_main_mem_mem;
    assign mem_release = (MEM_LAT == 1) || ((state == WAIT) && (cnt == CW'(MEM_LAT - 1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        ctl       = CTL_DEFAULT;
        state_nxt = state;
        cnt_nxt   = cnt;
        if (reset) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
        end else if (state == HALTED) begin
            if (bus.resume) begin
                // HLT retires out of MEM; EX/MEM takes a bubble in its place
                ctl.flush_exmem = 1'b1;
                state_nxt       = RUN;
            end else begin
                ctl = CTL_FREEZE;
            end
            ctl.halted = 1'b1;
        end else if (bus.is_halt) begin
            ctl       = CTL_FREEZE;
            state_nxt = HALTED;
            cnt_nxt   = '0;
        end else if (memacc && !mem_release) begin
            // EX is frozen here, so branch/load-use wait until release
            ctl       = CTL_FREEZE;
            state_nxt = WAIT;
            cnt_nxt   = (state == WAIT) ? cnt + 1'b1 : CW'(1);
        end else begin
            state_nxt   = RUN;
            cnt_nxt     = '0;
            ctl.dmem_we = bus.main_mem_write;
            if (bus.branch_taken_ex) begin
                ctl.flush_ifid = 1'b1;
                ctl.flush_idex = 1'b1;
            end else if (lu) begin
                ctl.pc_en      = 1'b0;
                ctl.en_ifid    = 1'b0;
                ctl.flush_idex = 1'b1;
            end
        end
    end

    assign bus.pc_en       = ctl.pc_en;
    assign bus.en_ifid     = ctl.en_ifid;
    assign bus.en_idex     = ctl.en_idex;
    assign bus.en_exmem    = ctl.en_exmem;
    assign bus.en_memwb    = ctl.en_memwb;
    assign bus.flush_ifid  = ctl.flush_ifid;
    assign bus.flush_idex  = ctl.flush_idex;
    assign bus.flush_exmem = ctl.flush_exmem;
    assign bus.flush_memwb = ctl.flush_memwb;
    assign bus.dmem_we     = ctl.dmem_we;
    assign bus.halted      = ctl.halted;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl at MEM_LAT=3 and MEM_LAT=1.
module tb_pipe_ctrl;

    typedef struct packed {
        logic       rst;
        logic [2:0] ra;
        logic [2:0] rb;
        logic       ura;
        logic       urb;
        logic       ld_ex;
        logic       rw_ex;
        logic [2:0] rwa;
        logic       br;
        logic       st;
        logic       ld_mem;
        logic       hlt;
        logic       res;
    } in_t;

    typedef struct {
        logic [10:0] v;
        string       nm;
    } exp_t;

    // {pc_en,en_ifid,en_idex,en_exmem,en_memwb, fl_ifid,fl_idex,fl_exmem,fl_memwb, dmem_we, halted}
    localparam logic [10:0] DEF    = 11'b11111_0000_0_0;
    localparam logic [10:0] STALL  = 11'b00001_0001_0_0;
    localparam logic [10:0] HALTH  = 11'b00001_0001_0_1;
    localparam logic [10:0] RESUME = 11'b11111_0010_0_1;
    localparam logic [10:0] STREL  = 11'b11111_0000_1_0;
    localparam logic [10:0] LU     = 11'b00111_0100_0_0;
    localparam logic [10:0] BR     = 11'b11111_1100_0_0;
    localparam logic [10:0] BRREL  = 11'b11111_1100_1_0;

    logic clk = 1'b0;
    logic rst3, rst1;
    int   checks = 0;
    int   errors = 0;
    exp_t q3[$];
    exp_t q1[$];

    pipe_ctrl_if bus3 ();
    pipe_ctrl_if bus1 ();

    pipe_ctrl #(.MEM_LAT(3)) dut3 (.clk(clk), .reset(rst3), .bus(bus3));
    pipe_ctrl #(.MEM_LAT(1)) dut1 (.clk(clk), .reset(rst1), .bus(bus1));

    always #5 clk = ~clk;

    logic [10:0] obs3, obs1;
    assign obs3 = {bus3.pc_en, bus3.en_ifid, bus3.en_idex, bus3.en_exmem, bus3.en_memwb,
                   bus3.flush_ifid, bus3.flush_idex, bus3.flush_exmem, bus3.flush_memwb,
                   bus3.dmem_we, bus3.halted};
    assign obs1 = {bus1.pc_en, bus1.en_ifid, bus1.en_idex, bus1.en_exmem, bus1.en_memwb,
                   bus1.flush_ifid, bus1.flush_idex, bus1.flush_exmem, bus1.flush_memwb,
                   bus1.dmem_we, bus1.halted};

    task automatic drive(input int sel, input in_t s);
        if (sel == 3) begin
            rst3 = s.rst;
            bus3.ra_id = s.ra;             bus3.rb_id = s.rb;
            bus3.use_ra_id = s.ura;        bus3.use_rb_id = s.urb;
            bus3.from_main_mem_ex = s.ld_ex; bus3.regwrite_ex = s.rw_ex;
            bus3.regwrite_adr_ex = s.rwa;  bus3.branch_taken_ex = s.br;
            bus3.main_mem_write = s.st;    bus3.from_main_mem_mem = s.ld_mem;
            bus3.is_halt = s.hlt;          bus3.resume = s.res;
        end else begin
            rst1 = s.rst;
            bus1.ra_id = s.ra;             bus1.rb_id = s.rb;
            bus1.use_ra_id = s.ura;        bus1.use_rb_id = s.urb;
            bus1.from_main_mem_ex = s.ld_ex; bus1.regwrite_ex = s.rw_ex;
            bus1.regwrite_adr_ex = s.rwa;  bus1.branch_taken_ex = s.br;
            bus1.main_mem_write = s.st;    bus1.from_main_mem_mem = s.ld_mem;
            bus1.is_halt = s.hlt;          bus1.resume = s.res;
        end
    endtask

    // One cycle: apply inputs just after the edge and queue what the outputs must be.
    task automatic cyc(input int sel, input in_t s, input logic [10:0] e, input string nm);
        exp_t x;
        @(posedge clk);
        #1;
        drive(sel, s);
        x.v  = e;
        x.nm = nm;
        if (sel == 3) q3.push_back(x);
        else          q1.push_back(x);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (q3.size() > 0) begin
            e = q3.pop_front();
            checks++;
            if (obs3 !== e.v) begin
                errors++;
                $display("FAIL %s dut3 got %b want %b", e.nm, obs3, e.v);
            end
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            checks++;
            if (obs1 !== e.v) begin
                errors++;
                $display("FAIL %s dut1 got %b want %b", e.nm, obs1, e.v);
            end
        end
    end

    initial begin
        in_t s;
        s = '0;
        s.rst = 1'b1;
        drive(3, s);
        drive(1, s);

        // ---------------- MEM_LAT = 3 ----------------
        s = '0; s.rst = 1'b1;  cyc(3, s, DEF, "rst3");
        s = '0;                cyc(3, s, DEF, "idle3");
        // store occupies MEM for 3 cycles, strobe on the last
        s = '0; s.st = 1'b1;   cyc(3, s, STALL, "st_t0");
                               cyc(3, s, STALL, "st_t1");
                               cyc(3, s, STREL, "st_t2");
        s = '0;                cyc(3, s, DEF, "st_t3");
        s = '0; s.ld_mem = 1'b1; cyc(3, s, STALL, "ld_t0");
                               cyc(3, s, STALL, "ld_t1");
                               cyc(3, s, DEF, "ld_t2");
        // branch suppressed while stalled, taken on release
        s = '0; s.st = 1'b1; s.br = 1'b1;
                               cyc(3, s, STALL, "br_stall0");
                               cyc(3, s, STALL, "br_stall1");
                               cyc(3, s, BRREL, "br_release");
        // load-use suppressed during stall
        s = '0; s.ld_mem = 1'b1; s.ld_ex = 1'b1; s.rw_ex = 1'b1; s.rwa = 3'd2; s.ra = 3'd2; s.ura = 1'b1;
                               cyc(3, s, STALL, "lu_stall0");
                               cyc(3, s, STALL, "lu_stall1");
                               cyc(3, s, LU, "lu_release");
        // reset in WAIT with cnt=1
        s = '0; s.st = 1'b1;   cyc(3, s, STALL, "rw_t0");
        s.rst = 1'b1;          cyc(3, s, DEF, "rw_rst");
        s = '0;                cyc(3, s, DEF, "rw_after");
        s = '0; s.st = 1'b1;   cyc(3, s, STALL, "rw_st0");
                               cyc(3, s, STALL, "rw_st1");
                               cyc(3, s, STREL, "rw_st2");
        // halt / resume
        s = '0; s.hlt = 1'b1;  cyc(3, s, STALL, "halt_t0");
        for (int i = 1; i <= 4; i++) cyc(3, s, HALTH, $sformatf("halt_t%0d", i));
        s.res = 1'b1;          cyc(3, s, RESUME, "resume_t5");
        s = '0;                cyc(3, s, DEF, "halt_t6");
        s = '0; s.res = 1'b1;  cyc(3, s, DEF, "res_ignored");
        // reset while halted
        s = '0; s.hlt = 1'b1;  cyc(3, s, STALL, "rh_t0");
                               cyc(3, s, HALTH, "rh_t1");
        s.rst = 1'b1;          cyc(3, s, DEF, "rh_rst");
        s = '0;                cyc(3, s, DEF, "rh_after");
        s = '0;                drive(3, s);

        // ---------------- MEM_LAT = 1 ----------------
        s = '0; s.rst = 1'b1;  cyc(1, s, DEF, "rst1");
        s = '0; s.ld_mem = 1'b1; s.ld_ex = 1'b1; s.rw_ex = 1'b1; s.rwa = 3'd6;
        for (int i = 0; i < 3; i++) cyc(1, s, DEF, $sformatf("ld_b2b%0d", i));
        s = '0; s.st = 1'b1;   cyc(1, s, STREL, "st1_a");
                               cyc(1, s, STREL, "st1_b");
        // load r3 in EX, ID reads rb=3
        s = '0; s.ld_ex = 1'b1; s.rw_ex = 1'b1; s.rwa = 3'd3; s.rb = 3'd3; s.urb = 1'b1;
                               cyc(1, s, LU, "lu_rb");
        s.ld_ex = 1'b0; s.rw_ex = 1'b0; s.ld_mem = 1'b1;
                               cyc(1, s, DEF, "lu_next");
        s = '0; s.ld_ex = 1'b1; s.rw_ex = 1'b1; s.rwa = 3'd5; s.ra = 3'd5; s.ura = 1'b1;
                               cyc(1, s, LU, "lu_ra");
        s.ura = 1'b0;          cyc(1, s, DEF, "lu_nouse");
        s.ura = 1'b1; s.rw_ex = 1'b0;
                               cyc(1, s, DEF, "lu_norw");
        s.rw_ex = 1'b1; s.ra = 3'd4;
                               cyc(1, s, DEF, "lu_noaddr");
        s.ra = 3'd5; s.br = 1'b1;
                               cyc(1, s, BR, "br_lu");
        s = '0; s.br = 1'b1;   cyc(1, s, BR, "br_only");
        s = '0;                cyc(1, s, DEF, "idle1");

        @(posedge clk);
        @(negedge clk);
        #1;
        if (q3.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d %0d want 0 0", q3.size(), q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
